permutation_result_collector: RTL and testbench

Reassembles the per-permutation result stream coming back out of the processing pipeline into one summed result per bot: the return path of the input module that expands each queued bot into a burst of up to six permutations. Consumes one tagged result per cycle, accumulates a burst (terminated by `lastInBurst`), and pushes the combined record into a 4-entry show-ahead output queue drained with a valid/ready handshake. Queue fullness is exported so the upstream bot scheduler can throttle new bursts.

---
 rtl/permutation_result_collector.sv | 125 ++++++++++++
 tb/tb_permutation_result_collector.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/permutation_result_collector.sv
// Folds the per-permutation result stream back into one summed record per bot
// and buffers finished records in a 4-entry show-ahead queue.
module permutation_result_collector #(
  parameter int RESULT_WIDTH     = 48,
  parameter int EXTRA_DATA_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          resultValid,
  input  logic [2:0]                    resultPermutation,
  input  logic [RESULT_WIDTH-1:0]       result,
  input  logic                          lastInBurst,
  input  logic [EXTRA_DATA_WIDTH-1:0]   extraDataIn,
  output logic [2:0]                    queueFullness,
  output logic [RESULT_WIDTH+2:0]       sumOut,
  output logic [5:0]                    permutationsSeenOut,
  output logic [EXTRA_DATA_WIDTH-1:0]   extraDataOut,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [2:0]                    errorFlags
);

  localparam int SW = RESULT_WIDTH + 3;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                        r_state, w_state_next;
  logic [SW-1:0]                 r_acc;
  logic [5:0]                    r_seen;
  logic [EXTRA_DATA_WIDTH-1:0]   r_acc_extra;
  logic [2:0]                    r_error;

  logic [SW-1:0]                 r_sum_mem   [0:3];
  logic [5:0]                    r_seen_mem  [0:3];
  logic [EXTRA_DATA_WIDTH-1:0]   r_extra_mem [0:3];
  logic [1:0]                    r_wr_ptr, r_rd_ptr;
  logic [2:0]                    r_count;

  logic                          w_perm_ok, w_accept, w_in_burst;
  logic [5:0]                    w_onehot, w_seen;
  logic [SW-1:0]                 w_sum;
  logic [EXTRA_DATA_WIDTH-1:0]   w_extra;
  logic                          w_dup, w_mismatch;
  logic                          w_push_req, w_pop, w_full, w_push, w_overflow;

  assign w_perm_ok  = (resultPermutation < 3'd6);
  assign w_accept   = resultValid && w_perm_ok;
  assign w_in_burst = (r_state == S_ACCUM);
  assign w_onehot   = 6'b000001 << resultPermutation;

  // The record being formed this cycle; in IDLE it starts from the incoming result alone.
  assign w_sum   = (w_in_burst ? r_acc : '0) + {3'b000, result};
  assign w_seen  = (w_in_burst ? r_seen : 6'b0) | w_onehot;
  assign w_extra = w_in_burst ? r_acc_extra : extraDataIn;

  assign w_dup      = (resultValid && !w_perm_ok) ||
                      (w_accept && w_in_burst && ((r_seen & w_onehot) != 6'b0));
  assign w_mismatch = w_accept && w_in_burst && (extraDataIn != r_acc_extra);

  assign w_push_req = w_accept && lastInBurst;
  assign w_pop      = (r_count != 3'd0) && outReady;
  assign w_full     = (r_count == 3'd4);
  // A simultaneous pop frees the slot the push needs.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_overflow = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) w_state_next = lastInBurst ? S_IDLE : S_ACCUM;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc       <= '0;
      r_seen      <= '0;
      r_acc_extra <= '0;
      r_error     <= '0;
    end else begin
      if (w_accept) begin
        r_acc       <= w_sum;
        r_seen      <= w_seen;
        r_acc_extra <= w_extra;
      end
      r_error <= r_error | {w_overflow, w_mismatch, w_dup};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sum_mem[r_wr_ptr]   <= w_sum;
      r_seen_mem[r_wr_ptr]  <= w_seen;
      r_extra_mem[r_wr_ptr] <= w_extra;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head outputs are forced to zero when the queue is empty so stale storage never leaks out.
  assign outValid            = (r_count != 3'd0);
  assign queueFullness       = r_count;
  assign sumOut              = outValid ? r_sum_mem[r_rd_ptr]   : '0;
  assign permutationsSeenOut = outValid ? r_seen_mem[r_rd_ptr]  : '0;
  assign extraDataOut        = outValid ? r_extra_mem[r_rd_ptr] : '0;
  assign errorFlags          = r_error;

endmodule

// File: tb/tb_permutation_result_collector.sv
// Scenario-driven bench for permutation_result_collector: expected records are
// queued as bursts are driven and compared as the output queue drains.
module tb_permutation_result_collector;

  localparam int RW = 48;
  localparam int EW = 12;

  typedef struct packed {
    logic [RW+2:0] sum;
    logic [5:0]    seen;
    logic [EW-1:0] extra;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          resultValid;
  logic [2:0]    resultPermutation;
  logic [RW-1:0] result;
  logic          lastInBurst;
  logic [EW-1:0] extraDataIn;
  logic [2:0]    queueFullness;
  logic [RW+2:0] sumOut;
  logic [5:0]    permutationsSeenOut;
  logic [EW-1:0] extraDataOut;
  logic          outValid;
  logic          outReady;
  logic [2:0]    errorFlags;

  int   checks = 0;
  int   errors = 0;
  rec_t sb[$];

  permutation_result_collector #(.RESULT_WIDTH(RW), .EXTRA_DATA_WIDTH(EW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .resultValid         (resultValid),
    .resultPermutation   (resultPermutation),
    .result              (result),
    .lastInBurst         (lastInBurst),
    .extraDataIn         (extraDataIn),
    .queueFullness       (queueFullness),
    .sumOut              (sumOut),
    .permutationsSeenOut (permutationsSeenOut),
    .extraDataOut        (extraDataOut),
    .outValid            (outValid),
    .outReady            (outReady),
    .errorFlags          (errorFlags)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst         = 1'b0;
    resultValid = 1'b0;
    lastInBurst = 1'b0;
    outReady    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drives one result for one cycle; returns 1 time unit after the sampling edge.
  task automatic send(input logic [2:0] p, input logic [RW-1:0] r, input logic l,
                      input logic [EW-1:0] e);
    resultValid       = 1'b1;
    resultPermutation = p;
    result            = r;
    lastInBurst       = l;
    extraDataIn       = e;
    @(posedge clk);
    #1;
    resultValid = 1'b0;
    lastInBurst = 1'b0;
    $display("send perm=%0d result=%0d last=%0d extra=0x%03h -> fullness=%0d flags=%b",
             p, r, l, e, queueFullness, errorFlags);
  endtask

  task automatic drain_scoreboard(input int n);
    int   got = 0;
    int   cyc = 0;
    rec_t exp_r;
    outReady = 1'b1;
    while (got < n && cyc < 50) begin
      if (outValid === 1'b1) begin
        exp_r = sb.pop_front();
        checks++;
        if (sumOut !== exp_r.sum || permutationsSeenOut !== exp_r.seen ||
            extraDataOut !== exp_r.extra) begin
          errors++;
          $display("FAIL drain_entry%0d: got sum=%0d seen=%b extra=0x%03h, want sum=%0d seen=%b extra=0x%03h",
                   got, sumOut, permutationsSeenOut, extraDataOut, exp_r.sum, exp_r.seen, exp_r.extra);
        end else begin
          $display("pop sum=%0d seen=%b extra=0x%03h", sumOut, permutationsSeenOut, extraDataOut);
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    outReady = 1'b0;
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries, want %0d", got, n);
    end
    checks++;
    if (queueFullness !== 3'd0 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: fullness=%0d valid=%b, want 0 and 0", queueFullness, outValid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (outValid !== 1'b0 || queueFullness !== 3'd0 || errorFlags !== 3'd0 ||
        sumOut !== '0 || permutationsSeenOut !== 6'd0 || extraDataOut !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b fullness=%0d flags=%b sum=%0d seen=%b extra=0x%03h, want all 0",
               outValid, queueFullness, errorFlags, sumOut, permutationsSeenOut, extraDataOut);
    end
  endtask

  task automatic test_basic_burst();
    rec_t r;
    apply_reset();
    send(3'd5, 48'd10, 1'b0, 12'h0AB);
    send(3'd3, 48'd20, 1'b0, 12'h0AB);
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL basic_midburst_valid: got %b want 0", outValid);
    end
    r.sum = 51'd60; r.seen = 6'b101001; r.extra = 12'h0AB;
    sb.push_back(r);
    send(3'd0, 48'd30, 1'b1, 12'h0AB);
    checks++;
    if (outValid !== 1'b1 || queueFullness !== 3'd1) begin
      errors++;
      $display("FAIL basic_latency: valid=%b fullness=%0d, want 1 and 1", outValid, queueFullness);
    end
    checks++;
    if (errorFlags !== 3'b000) begin
      errors++;
      $display("FAIL basic_flags: got %b want 000", errorFlags);
    end
    drain_scoreboard(1);
  endtask

  task automatic test_overflow();
    rec_t r;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        r.sum = 51'(i + 1); r.seen = 6'(1 << i); r.extra = 12'(12'h100 + i);
        sb.push_back(r);
      end
      send(3'(i), 48'(i + 1), 1'b1, 12'(12'h100 + i));
    end
    checks++;
    if (queueFullness !== 3'd4) begin
      errors++;
      $display("FAIL overflow_fullness: got %0d want 4", queueFullness);
    end
    checks++;
    if (errorFlags !== 3'b100) begin
      errors++;
      $display("FAIL overflow_flags: got %b want 100", errorFlags);
    end
    drain_scoreboard(4);
  endtask

  task automatic test_max_sum();
    rec_t r;
    logic [RW+2:0] e;
    apply_reset();
    e = '0;
    for (int i = 0; i < 6; i++) e = e + {3'b000, {RW{1'b1}}};
    r.sum = e; r.seen = 6'b111111; r.extra = 12'h5A5;
    sb.push_back(r);
    for (int i = 5; i >= 0; i--) send(3'(i), {RW{1'b1}}, (i == 0), 12'h5A5);
    checks++;
    if (errorFlags !== 3'b000) begin
      errors++;
      $display("FAIL maxsum_flags: got %b want 000", errorFlags);
    end
    drain_scoreboard(1);
  endtask

  task automatic test_errors();
    rec_t r;
    apply_reset();
    r.sum = 51'd12; r.seen = 6'b000100; r.extra = 12'h011;
    sb.push_back(r);
    send(3'd2, 48'd5, 1'b0, 12'h011);
    send(3'd2, 48'd7, 1'b1, 12'h011);
    checks++;
    if (errorFlags !== 3'b001) begin
      errors++;
      $display("FAIL dup_flags: got %b want 001", errorFlags);
    end
    r.sum = 51'd7; r.seen = 6'b010010; r.extra = 12'h033;
    sb.push_back(r);
    send(3'd1, 48'd3, 1'b0, 12'h033);
    send(3'd4, 48'd4, 1'b1, 12'h044);
    checks++;
    if (errorFlags !== 3'b011) begin
      errors++;
      $display("FAIL mismatch_flags: got %b want 011", errorFlags);
    end
    drain_scoreboard(2);
    // Permutation index 7 must be ignored even when it carries lastInBurst.
    apply_reset();
    send(3'd7, 48'd99, 1'b1, 12'h077);
    checks++;
    if (errorFlags !== 3'b001 || queueFullness !== 3'd0) begin
      errors++;
      $display("FAIL badperm: flags=%b fullness=%0d, want 001 and 0", errorFlags, queueFullness);
    end
  endtask

  task automatic test_full_push_pop();
    rec_t r;
    rec_t h;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      r.sum = 51'(20 + i); r.seen = 6'(1 << i); r.extra = 12'(12'h200 + i);
      sb.push_back(r);
      send(3'(i), 48'(20 + i), 1'b1, 12'(12'h200 + i));
    end
    checks++;
    if (queueFullness !== 3'd4) begin
      errors++;
      $display("FAIL fullpp_prefill: got %0d want 4", queueFullness);
    end
    h = sb.pop_front();
    checks++;
    if (outValid !== 1'b1 || sumOut !== h.sum || permutationsSeenOut !== h.seen) begin
      errors++;
      $display("FAIL fullpp_head: valid=%b sum=%0d seen=%b, want 1 sum=%0d seen=%b",
               outValid, sumOut, permutationsSeenOut, h.sum, h.seen);
    end
    outReady = 1'b1;
    r.sum = 51'd77; r.seen = 6'b100000; r.extra = 12'h2FF;
    sb.push_back(r);
    send(3'd5, 48'd77, 1'b1, 12'h2FF);
    outReady = 1'b0;
    checks++;
    if (queueFullness !== 3'd4 || errorFlags !== 3'b000) begin
      errors++;
      $display("FAIL fullpp_same_cycle: fullness=%0d flags=%b, want 4 and 000",
               queueFullness, errorFlags);
    end
    drain_scoreboard(4);
  endtask

  task automatic test_reset_mid_burst();
    rec_t r;
    apply_reset();
    send(3'd1, 48'd4, 1'b0, 12'h0C0);
    send(3'd1, 48'd4, 1'b0, 12'h0C0);
    apply_reset();
    checks++;
    if (errorFlags !== 3'b000 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: flags=%b valid=%b, want 000 and 0", errorFlags, outValid);
    end
    r.sum = 51'd9; r.seen = 6'b001000; r.extra = 12'h0D0;
    sb.push_back(r);
    send(3'd3, 48'd9, 1'b1, 12'h0D0);
    checks++;
    if (errorFlags !== 3'b000 || queueFullness !== 3'd1) begin
      errors++;
      $display("FAIL midreset_burst: flags=%b fullness=%0d, want 000 and 1", errorFlags, queueFullness);
    end
    drain_scoreboard(1);
  endtask

  initial begin
    rst               = 1'b0;
    resultValid       = 1'b0;
    resultPermutation = 3'd0;
    result            = '0;
    lastInBurst       = 1'b0;
    extraDataIn       = '0;
    outReady          = 1'b0;
    test_reset();
    test_basic_burst();
    test_overflow();
    test_max_sum();
    test_errors();
    test_full_push_pop();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
